// File: rtl/oled_page_streamer.sv
// oled_page_streamer
// Walks the display frame buffer page by page and feeds every byte to the
// OLED SPI byte sender. Each page is preceded by a 4-byte page-address
// command preamble (DC=0), followed by COLS data bytes read from display
// memory (DC=1). Every byte goes through the SPI_EN/SPI_FIN handshake.
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous, active-low reset
//   START    in   frame request, sampled only while idle
//   BUSY     out  high while a frame is being streamed
//   DONE     out  one-cycle pulse after the last data byte completes
//   MEM_ADDR out  display-memory read address (synchronous RAM)
//   MEM_DATA in   read data, valid one cycle after MEM_ADDR
//   SPI_EN   out  byte-send request to the SPI sender
//   SPI_DATA out  byte to send
//   SPI_FIN  in   sender done flag, high until SPI_EN drops
//   DC       out  OLED data/command select (0=command, 1=data)
module oled_page_streamer #(
    parameter int PAGES  = 4,
    parameter int COLS   = 128,
    parameter int ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic              SPI_EN,
    output logic [7:0]        SPI_DATA,
    input  logic              SPI_FIN,
    output logic              DC
);

    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_LOAD  = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DATA_LOAD = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_CLR  = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     page_r;
    logic [CW-1:0]     col_r;
    logic [1:0]        cmd_idx_r;
    logic              busy_r;
    logic              done_r;
    logic              spi_en_r;
    logic [7:0]        spi_data_r;
    logic              dc_r;
    logic [ADDR_W-1:0] mem_addr_r;

    // Linear display-memory address of (page, col), truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [PW-1:0] pg,
                                                     input logic [CW-1:0] cl);
        logic [31:0] a;
        a = 32'(pg) * 32'(COLS) + 32'(cl);
        return a[ADDR_W-1:0];
    endfunction

    // Page-address command preamble: 0x22, page, 0x00, 0x10.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx,
                                            input logic [PW-1:0] pg);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h22;
            2'd1:    b = 8'(pg);
            2'd2:    b = 8'h00;
            2'd3:    b = 8'h10;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame sequencer: all outputs are registered here.
    // MEM_ADDR is updated on the edge that enters FETCH, so the synchronous
    // RAM holds the address during FETCH and returns its data in DATA_LOAD.
    // SPI_DATA/DC are loaded in CMD_LOAD/DATA_LOAD, one cycle before SEND
    // raises SPI_EN, so the byte is stable when the sender captures it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r    <= ST_IDLE;
            page_r     <= '0;
            col_r      <= '0;
            cmd_idx_r  <= 2'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            spi_en_r   <= 1'b0;
            spi_data_r <= 8'h00;
            dc_r       <= 1'b0;
            mem_addr_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        page_r    <= '0;
                        col_r     <= '0;
                        cmd_idx_r <= 2'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_CMD_LOAD;
                    end
                end
                ST_CMD_LOAD: begin
                    spi_data_r <= cmd_byte(cmd_idx_r, page_r);
                    dc_r       <= 1'b0;
                    state_r    <= ST_SEND;
                end
                ST_FETCH: begin
                    state_r <= ST_DATA_LOAD;
                end
                ST_DATA_LOAD: begin
                    spi_data_r <= MEM_DATA;
                    dc_r       <= 1'b1;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    if (SPI_FIN) begin
                        spi_en_r <= 1'b0;
                        state_r  <= ST_WAIT_CLR;
                    end else begin
                        spi_en_r <= 1'b1;
                    end
                end
                ST_WAIT_CLR: begin
                    spi_en_r <= 1'b0;
                    // dc_r still describes the byte just sent.
                    if (!SPI_FIN) begin
                        if (!dc_r) begin
                            if (cmd_idx_r != 2'd3) begin
                                cmd_idx_r <= cmd_idx_r + 2'd1;
                                state_r   <= ST_CMD_LOAD;
                            end else begin
                                cmd_idx_r  <= 2'd0;
                                col_r      <= '0;
                                mem_addr_r <= fetch_addr(page_r, '0);
                                state_r    <= ST_FETCH;
                            end
                        end else if (col_r != COL_LAST) begin
                            col_r      <= col_r + CW'(1);
                            mem_addr_r <= fetch_addr(page_r, col_r + CW'(1));
                            state_r    <= ST_FETCH;
                        end else if (page_r != PAGE_LAST) begin
                            page_r  <= page_r + PW'(1);
                            state_r <= ST_CMD_LOAD;
                        end else begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    spi_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign MEM_ADDR = mem_addr_r;
    assign SPI_EN   = spi_en_r;
    assign SPI_DATA = spi_data_r;
    assign DC       = dc_r;

endmodule
